flag_unit: RTL and testbench

FLAG_UNIT -- requirements
Module: flag_unit

---
 rtl/flag_pkg.sv | 26 ++
 rtl/flag_mask_decode.sv | 21 ++
 rtl/flag_unit.sv | 95 +++++++++
 tb/tb_flag_unit.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/flag_pkg.sv
// Shared definitions for the condition-flag unit: opcodes, flag bit positions,
// mask width and the branch-stall FSM state encoding.
package flag_pkg;

  localparam int MASK_W = 3;

  // Flag vector order is {Z,V,N}, matching the branch-condition encoding.
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 0;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_XOR = 4'h2;
  localparam logic [3:0] OP_RED = 4'h3;
  localparam logic [3:0] OP_SLL = 4'h4;
  localparam logic [3:0] OP_SRA = 4'h5;
  localparam logic [3:0] OP_ROR = 4'h6;

  typedef logic [MASK_W-1:0] flag_vec_t;

  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE = 1'b0;
  localparam state_t ST_WAIT = 1'b1;

endpackage

// File: rtl/flag_mask_decode.sv
// Opcode to flag-update mask decode, {Z,V,N}. Purely combinational.
module flag_mask_decode
  import flag_pkg::*;
(
  input  logic [3:0]  opcode,
  output flag_vec_t   mask
);

  always_comb begin
    mask = '0;
    case (opcode)
      OP_ADD, OP_SUB: mask = 3'b111;
      OP_XOR, OP_RED, OP_SLL, OP_SRA, OP_ROR: begin
        mask          = '0;
        mask[FLAG_Z]  = 1'b1;
      end
      default: mask = '0;
    endcase
  end

endmodule

// File: rtl/flag_unit.sv
// Condition-flag register with branch interlock and stall counter.
// Define FLAG_FWD_EN to forward same-cycle EX flags to a branch in ID.
module flag_unit
  import flag_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [3:0]  ex_opcode,
  input  logic [15:0] alu_result,
  input  logic        alu_ovfl,
  input  logic        stall_ex,
  input  logic        flush,
  input  logic        br_req,
  output logic [2:0]  flags_out,
  output logic        br_stall,
  output logic [15:0] stall_cnt,
  output state_t      fsm_state
);

  // Handshake: br_req asks for flags this cycle; br_stall=1 means flags_out is
  // not yet valid for it and ID/IF must hold. No other handshake exists here.

  flag_vec_t mask;
  flag_vec_t new_flags;
  flag_vec_t merged;
  flag_vec_t flags_q;
  state_t    state_q;
  state_t    state_d;
  logic      setter;
  logic      pending;
  logic      fwd;

  flag_mask_decode u_decode (
    .opcode (ex_opcode),
    .mask   (mask)
  );

  always_comb begin
    new_flags         = '0;
    new_flags[FLAG_Z] = (alu_result == 16'h0000);
    new_flags[FLAG_V] = alu_ovfl;
    new_flags[FLAG_N] = alu_result[15];
  end

  assign merged  = (new_flags & mask) | (flags_q & ~mask);
  assign pending = ex_valid & ~flush & (|mask);
  assign setter  = pending & ~stall_ex;

`ifdef FLAG_FWD_EN
  assign fwd = setter;
`else
  assign fwd = 1'b0;
`endif

  // Gated by rst so the outputs fall to zero the moment reset asserts.
  assign br_stall  = ~rst & br_req & pending & ~fwd;
  assign flags_out = rst ? 3'b000 : (fwd ? merged : flags_q);
  assign fsm_state = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q <= '0;
    end else if (setter) begin
      flags_q <= merged;
    end
  end

  // WAIT only marks an ongoing stall episode; br_stall itself is combinational.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (br_stall) state_d = ST_WAIT;
      ST_WAIT: if (!pending) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= 16'h0000;
    end else if (br_stall && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'h0001;
    end
  end

endmodule

// File: tb/tb_flag_unit.sv
// Self-checking bench for flag_unit: table of single-cycle vectors plus
// hand-written multi-cycle sequences (stall/flush, saturation, async reset).
module tb_flag_unit;
  import flag_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [3:0]  ex_opcode;
  logic [15:0] alu_result;
  logic        alu_ovfl;
  logic        stall_ex;
  logic        flush;
  logic        br_req;
  logic [2:0]  flags_out;
  logic        br_stall;
  logic [15:0] stall_cnt;
  state_t      fsm_state;

  flag_unit dut (
    .clk        (clk),
    .rst        (rst),
    .ex_valid   (ex_valid),
    .ex_opcode  (ex_opcode),
    .alu_result (alu_result),
    .alu_ovfl   (alu_ovfl),
    .stall_ex   (stall_ex),
    .flush      (flush),
    .br_req     (br_req),
    .flags_out  (flags_out),
    .br_stall   (br_stall),
    .stall_cnt  (stall_cnt),
    .fsm_state  (fsm_state)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [2:0] exp_q[$];
  logic [2:0] cur_flags;
  int         exp_cnt;
  logic       fwd_build;

  typedef struct {
    logic        valid;
    logic [3:0]  op;
    logic [15:0] res;
    logic        ovfl;
    logic        stall;
    logic        flush;
    logic        br;
    logic        setter;
    logic        exp_stall;
    logic [2:0]  exp_flags;
  } vec_t;

  vec_t tbl[15];

  function automatic vec_t mk(logic valid, logic [3:0] op, logic [15:0] res, logic ovfl,
                              logic stall, logic fl, logic br, logic setter,
                              logic exp_stall, logic [2:0] exp_flags);
    vec_t v;
    v.valid = valid; v.op = op; v.res = res; v.ovfl = ovfl; v.stall = stall;
    v.flush = fl; v.br = br; v.setter = setter; v.exp_stall = exp_stall;
    v.exp_flags = exp_flags;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic valid, input logic [3:0] op, input logic [15:0] res,
                       input logic ovfl, input logic stall, input logic fl, input logic br);
    ex_valid = valid; ex_opcode = op; alu_result = res; alu_ovfl = ovfl;
    stall_ex = stall; flush = fl; br_req = br;
  endtask

  task automatic drive_idle();
    drive(1'b0, 4'h0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive_idle();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cur_flags = 3'b000;
    exp_cnt   = 0;
  endtask

  initial begin
`ifdef FLAG_FWD_EN
    fwd_build = 1'b1;
`else
    fwd_build = 1'b0;
`endif
    //            valid op    res       ov stl fl br  set stl flags
    tbl[0]  = mk(1, 4'h0, 16'h0000, 1, 0, 0, 0, 1, 0, 3'b110);
    tbl[1]  = mk(1, 4'h1, 16'h8000, 1, 0, 0, 0, 1, 0, 3'b011);
    tbl[2]  = mk(1, 4'h2, 16'h8001, 1, 0, 0, 0, 1, 0, 3'b011);
    tbl[3]  = mk(1, 4'h1, 16'hFFFE, 0, 0, 0, 1, 1, 1, 3'b001);
    tbl[4]  = mk(1, 4'h3, 16'h0000, 0, 0, 0, 0, 1, 0, 3'b101);
    tbl[5]  = mk(1, 4'h7, 16'h0000, 1, 0, 0, 1, 0, 0, 3'b101);
    tbl[6]  = mk(1, 4'hF, 16'h8000, 0, 0, 0, 0, 0, 0, 3'b101);
    tbl[7]  = mk(0, 4'h0, 16'h0000, 0, 0, 0, 1, 0, 0, 3'b101);
    tbl[8]  = mk(1, 4'h0, 16'h8000, 1, 0, 1, 1, 0, 0, 3'b101);
    tbl[9]  = mk(1, 4'h4, 16'h1234, 1, 0, 0, 0, 1, 0, 3'b001);
    tbl[10] = mk(1, 4'h5, 16'h0000, 0, 0, 0, 1, 1, 1, 3'b101);
    tbl[11] = mk(1, 4'h6, 16'h8000, 1, 0, 0, 0, 1, 0, 3'b001);
    tbl[12] = mk(1, 4'h0, 16'h7FFF, 1, 0, 0, 0, 1, 0, 3'b010);
    tbl[13] = mk(1, 4'h1, 16'h0000, 0, 1, 0, 0, 0, 0, 3'b010);
    tbl[14] = mk(1, 4'h2, 16'h0000, 0, 1, 0, 1, 0, 1, 3'b010);

    // Reset state, asserted before any clock edge.
    drive_idle();
    rst = 1'b1;
    #1;
    check("reset_flags", 32'(flags_out), 32'd0);
    check("reset_br_stall", 32'(br_stall), 32'd0);
    check("reset_stall_cnt", 32'(stall_cnt), 32'd0);
    check("reset_state", 32'(fsm_state), 32'(ST_IDLE));
    @(negedge clk);
    rst = 1'b0;
    cur_flags = 3'b000;
    exp_cnt   = 0;

    for (int i = 0; i < 15; i++) begin
      logic es;
      logic [2:0] ef;
      logic [2:0] got;
      @(negedge clk);
      drive(tbl[i].valid, tbl[i].op, tbl[i].res, tbl[i].ovfl, tbl[i].stall,
            tbl[i].flush, tbl[i].br);
      #1;
      es = fwd_build ? (tbl[i].exp_stall & tbl[i].stall) : tbl[i].exp_stall;
      ef = (fwd_build && tbl[i].setter) ? tbl[i].exp_flags : cur_flags;
      check($sformatf("vec%0d_br_stall", i), 32'(br_stall), 32'(es));
      check($sformatf("vec%0d_flags_now", i), 32'(flags_out), 32'(ef));
      if (es) exp_cnt++;
      exp_q.push_back(tbl[i].exp_flags);
      @(posedge clk);
      #1;
      drive_idle();
      #1;
      got = exp_q.pop_front();
      check($sformatf("vec%0d_flags_reg", i), 32'(flags_out), 32'(got));
      cur_flags = got;
    end
    check("table_stall_cnt", 32'(stall_cnt), 32'(exp_cnt));

    // Stalled ADD held 3 cycles with a waiting branch, then flushed.
    do_reset();
    @(negedge clk);
    drive(1, OP_SUB, 16'h8000, 0, 0, 0, 0);
    @(posedge clk);
    cur_flags = 3'b001;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      drive(1, OP_ADD, 16'h0000, 1, 1, 0, 1);
      #1;
      check($sformatf("hold%0d_br_stall", c), 32'(br_stall), 32'd1);
      if (c > 0) check($sformatf("hold%0d_state", c), 32'(fsm_state), 32'(ST_WAIT));
      exp_cnt++;
    end
    @(negedge clk);
    flush = 1'b1;
    #1;
    check("flush_br_stall", 32'(br_stall), 32'd0);
    @(posedge clk);
    #1;
    check("flush_state", 32'(fsm_state), 32'(ST_IDLE));
    check("flush_flags", 32'(flags_out), 32'(cur_flags));
    check("flush_stall_cnt", 32'(stall_cnt), 32'd3);

    // Unstalled SUB meets a branch: one stall cycle, or forwarded flags.
    @(negedge clk);
    drive(1, OP_SUB, 16'h0000, 1, 0, 0, 1);
    #1;
    check("sub_br_stall", 32'(br_stall), fwd_build ? 32'd0 : 32'd1);
    check("sub_flags_now", 32'(flags_out), fwd_build ? 32'b110 : 32'(cur_flags));
    if (!fwd_build) exp_cnt++;
    @(posedge clk);
    #1;
    drive(0, 4'h0, 16'h0000, 0, 0, 0, 1);
    #1;
    check("sub_after_br_stall", 32'(br_stall), 32'd0);
    check("sub_after_flags", 32'(flags_out), 32'b110);
    check("sub_after_stall_cnt", 32'(stall_cnt), 32'(exp_cnt));
    @(negedge clk);
    drive(1, OP_SUB, 16'hFFFE, 0, 0, 0, 1);
    #1;
    check("sub_fffe_flags_now", 32'(flags_out), fwd_build ? 32'b001 : 32'b110);

    // Saturation of stall_cnt, then async reset in the middle of the stall.
    do_reset();
    @(negedge clk);
    drive(1, OP_ADD, 16'h0000, 1, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    drive(1, OP_ADD, 16'h0000, 1, 1, 0, 1);
    repeat (65534) @(posedge clk);
    #1;
    check("sat_near", 32'(stall_cnt), 32'hFFFE);
    repeat (4) @(posedge clk);
    #1;
    check("sat_hold", 32'(stall_cnt), 32'hFFFF);
    check("sat_flags", 32'(flags_out), 32'b110);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_br_stall", 32'(br_stall), 32'd0);
    check("midrst_flags", 32'(flags_out), 32'd0);
    check("midrst_stall_cnt", 32'(stall_cnt), 32'd0);
    check("midrst_state", 32'(fsm_state), 32'(ST_IDLE));
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("postrst_br_stall", 32'(br_stall), 32'd1);
    @(posedge clk);
    #1;
    check("postrst_stall_cnt", 32'(stall_cnt), 32'd1);
    check("postrst_state", 32'(fsm_state), 32'(ST_WAIT));
    check("postrst_flags", 32'(flags_out), 32'd0);

    @(negedge clk);
    drive_idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
